reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side companion of the register file. Holds the MEM/WB pipeline register and drives the register file's single write port: writeRpoint, writeData and writeEnable.
- Keeps a per-register pending-write scoreboard. Decode sets an entry at issue, and the entry clears at retire.
- Decode queries the scoreboard for RAW hazards on rs/rt.
- The register file commits on negedge clk, so data driven here in cycle N is readable by decode later in cycle N.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- CNT_W, 2, width of the per-register pending counter (max in-flight writers to one register = 2**CNT_W-1)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold MEM/WB register contents
- flush  in  1  invalidate the MEM/WB entry being captured
- mem_valid  in  1  MEM stage holds a real instruction
- mem_regWrite  in  1  instruction writes a register
- mem_memToReg  in  1  1 = write load data, 0 = write ALU result
- mem_rd  in  ADDR_W  destination register
- mem_aluResult  in  DATA_W  ALU result
- mem_loadData  in  DATA_W  load data
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination of the issued instruction
- rs, rt  in  ADDR_W  decode source registers
- writeRpoint  out  ADDR_W  to register file
- writeData  out  DATA_W  to register file
- writeEnable  out  1  to register file
- busy_rs, busy_rt  out  1  source has a pending write (combinational from scoreboard)
- sb_overflow  out  1  sticky: issue attempted while the counter was saturated
- retire_cnt  out  32  count of committed writes

Behaviour:
- Reset (async, rst_n=0):
  - WB valid, writeEnable, writeRpoint, writeData, retire_cnt and sb_overflow all go to 0.
  - All pending counters go to 0.
- MEM/WB capture on posedge:
  - stall=1: hold all fields. stall takes priority over flush.
  - else flush=1: wb_valid<=0, data fields don't care.
  - else: wb_valid<=mem_valid; rd, regWrite and selected data are captured. Data = mem_memToReg ? mem_loadData : mem_aluResult. The mux is applied at capture.
- Write port (combinational from the WB register):
  - writeEnable = wb_valid & wb_regWrite & (wb_rd!=0).
  - writeRpoint = wb_rd, writeData = wb_data.
- Retire: a cycle with writeEnable=1 and stall=0 is one retire.
  - During stall the WB entry is held. writeEnable stays asserted, so the register file rewrites the same value (idempotent), but retire is counted only once: on the cycle the entry leaves, i.e. stall=0.
- Scoreboard: cnt[r] (CNT_W bits) per register. On posedge:
  - inc = issue_valid & issue_rd!=0.
  - dec = retire.
  - Same register, inc and dec both set: cnt unchanged.
  - inc with cnt==max: cnt holds and sb_overflow<=1.
  - dec with cnt==0: cnt holds. This case cannot occur in normal operation.
  - cnt[0] is always 0.
- busy_rs = cnt[rs]!=0; busy_rt = cnt[rt]!=0. Register 0 is never busy.
- retire_cnt increments by 1 per retire and wraps at 2**32.
- Reset mid-operation: the in-flight WB entry is dropped and the scoreboard clears. The pipeline must flush alongside.

Optional Feature:
- WB_BYPASS_EN defined:
  - The current-cycle retire to register r also masks busy for r, but only when cnt[r]==1. Rationale: the negedge write makes the value readable this cycle.
  - Adds outputs bypass_hit_rs/bypass_hit_rt, each asserted when its masking applies.
- Undefined: busy_rs/busy_rt reflect cnt only; bypass ports are absent.

Decomposition:
- Shared package (pipeline_pkg): DATA_W, ADDR_W, REG_COUNT and an mem_wb_t struct (valid, regWrite, rd, data).
- One natural sub-module: wb_scoreboard, containing the counter array, inc/dec logic, busy lookup and overflow flag.
- The parent module holds the MEM/WB register, the write-port logic and retire_cnt.

Test Plan:
- Reset: rst_n low mid-stream, including between clock edges → writeEnable=0, busy_rs=busy_rt=0 for all r, retire_cnt=0 immediately.
- Write path: mem_valid=1, regWrite=1, memToReg=1, rd=5, loadData=0xDEADBEEF, aluResult=0x1 → next cycle writeRpoint=5, writeData=0xDEADBEEF, writeEnable=1, retire_cnt=1.
- r0 suppression: rd=0, regWrite=1 → writeEnable=0, retire_cnt unchanged. issue_rd=0 → busy never asserted.
- Scoreboard: issue rd=7 twice, then retire rd=7 once → busy for rs=7 stays 1; second retire → 0. Issue and retire of rd=7 in the same cycle → count unchanged.
- Stall/flush: stall=1 for 3 cycles with an entry for rd=9 → outputs held, retire_cnt increments once, on release. flush=1 with stall=0 → writeEnable=0 next cycle. Both asserted → hold.
- Overflow: 4 issues to rd=3 with no retire → cnt=3, sb_overflow=1 and sticky until reset. Under WB_BYPASS_EN: cnt[3]=1 with retire rd=3 this cycle → busy_rs=0, bypass_hit_rs=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the write-back slice: default widths and the
// MEM/WB entry layout used at the register-file write port.
package pipeline_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int CNT_W     = 2;
    localparam int REG_COUNT = 2 ** ADDR_W;

    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } mem_wb_t;

endpackage

// File: rtl/reg_writeback_if.sv
// MEM-stage result bus into the write-back stage and the register-file write
// port coming back out of it.
interface reg_writeback_if
    import pipeline_pkg::*;
#(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int ADDR_W = pipeline_pkg::ADDR_W
) ();

    logic              mem_valid;
    logic              mem_regWrite;
    logic              mem_memToReg;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_aluResult;
    logic [DATA_W-1:0] mem_loadData;

    logic [ADDR_W-1:0] writeRpoint;
    logic [DATA_W-1:0] writeData;
    logic              writeEnable;

    // master: the MEM stage side that produces results and observes the write port
    modport master (
        output mem_valid, mem_regWrite, mem_memToReg, mem_rd, mem_aluResult, mem_loadData,
        input  writeRpoint, writeData, writeEnable
    );

    // slave: the write-back stage
    modport slave (
        input  mem_valid, mem_regWrite, mem_memToReg, mem_rd, mem_aluResult, mem_loadData,
        output writeRpoint, writeData, writeEnable
    );

endinterface

// File: rtl/reg_writeback_scoreboard.sv
// Per-register pending-write counters with RAW busy lookup for decode.
// WB_BYPASS_EN: a retire happening this cycle clears busy when it is the last pending writer.
module wb_scoreboard
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = pipeline_pkg::ADDR_W,
    parameter int CNT_W  = pipeline_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              retire,
    input  logic [ADDR_W-1:0] retire_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              busy_rs,
    output logic              busy_rt,
`ifdef WB_BYPASS_EN
    output logic              bypass_hit_rs,
    output logic              bypass_hit_rt,
`endif
    output logic              sb_overflow
);

    localparam int               REGS    = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_p1  [REGS];
    logic [CNT_W-1:0] cnt_nxt [REGS];
    logic             inc;
    logic             ovf_set;
    logic             hit_rs;
    logic             hit_rt;

    // Saturating up/down step; simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                  input logic inc_hit,
                                                  input logic dec_hit);
        logic [CNT_W-1:0] res;
        res = cur;
        if (inc_hit && !dec_hit && cur != CNT_MAX)
            res = cur + CNT_ONE;
        else if (dec_hit && !inc_hit && cur != '0)
            res = cur - CNT_ONE;
        return res;
    endfunction

    assign inc = issue_valid && (issue_rd != '0);

    always_comb begin
        ovf_set = 1'b0;
        for (int i = 0; i < REGS; i++) begin
            cnt_nxt[i] = '0;
            if (i != 0) begin
                cnt_nxt[i] = cnt_step(cnt_p1[i],
                                      inc && (issue_rd == ADDR_W'(i)),
                                      retire && (retire_rd == ADDR_W'(i)));
                if (inc && (issue_rd == ADDR_W'(i)) && !(retire && (retire_rd == ADDR_W'(i)))
                    && (cnt_p1[i] == CNT_MAX))
                    ovf_set = 1'b1;
            end
        end
    end

    // ---- scoreboard state (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++)
                cnt_p1[i] <= '0;
            sb_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < REGS; i++)
                cnt_p1[i] <= cnt_nxt[i];
            if (ovf_set)
                sb_overflow <= 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Negedge register-file write makes the retiring value visible to decode this cycle.
    assign hit_rs        = retire && (retire_rd == rs) && (cnt_p1[rs] == CNT_ONE);
    assign hit_rt        = retire && (retire_rd == rt) && (cnt_p1[rt] == CNT_ONE);
    assign bypass_hit_rs = hit_rs;
    assign bypass_hit_rt = hit_rt;
`else
    assign hit_rs = 1'b0;
    assign hit_rt = 1'b0;
`endif

    assign busy_rs = (cnt_p1[rs] != '0) && !hit_rs;
    assign busy_rt = (cnt_p1[rt] != '0) && !hit_rt;

endmodule

// File: rtl/reg_writeback.sv
// MEM/WB pipeline register, register-file write port, retire counter and the
// pending-write scoreboard. Optional macro WB_BYPASS_EN adds same-cycle busy masking.
module reg_writeback
    import pipeline_pkg::*;
#(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int ADDR_W = pipeline_pkg::ADDR_W,
    parameter int CNT_W  = pipeline_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_writeback_if.slave    wb,
    input  logic              stall,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              busy_rs,
    output logic              busy_rt,
`ifdef WB_BYPASS_EN
    output logic              bypass_hit_rs,
    output logic              bypass_hit_rt,
`endif
    output logic              sb_overflow,
    output logic [31:0]       retire_cnt
);

    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t wb_p1;
    logic      retire;

    // ---- MEM -> WB boundary (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_p1 <= '0;
        end else if (!stall) begin
            if (flush) begin
                wb_p1.valid <= 1'b0;
            end else begin
                wb_p1.valid    <= wb.mem_valid;
                wb_p1.regWrite <= wb.mem_regWrite;
                wb_p1.rd       <= wb.mem_rd;
                wb_p1.data     <= wb.mem_memToReg ? wb.mem_loadData : wb.mem_aluResult;
            end
        end
    end

    assign wb.writeEnable = wb_p1.valid && wb_p1.regWrite && (wb_p1.rd != '0);
    assign wb.writeRpoint = wb_p1.rd;
    assign wb.writeData   = wb_p1.data;

    // A stalled entry keeps rewriting the same value; it only retires when it leaves.
    assign retire = wb.writeEnable && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (retire)
            retire_cnt <= retire_cnt + 32'd1;
    end

    wb_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .retire        (retire),
        .retire_rd     (wb_p1.rd),
        .rs            (rs),
        .rt            (rt),
        .busy_rs       (busy_rs),
        .busy_rt       (busy_rt),
`ifdef WB_BYPASS_EN
        .bypass_hit_rs (bypass_hit_rs),
        .bypass_hit_rt (bypass_hit_rt),
`endif
        .sb_overflow   (sb_overflow)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized self-checking bench for reg_writeback against a pending-count /
// retire-count reference model.
module tb_reg_writeback;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam int CMAX = 3;

    logic          clk;
    logic          rst_n;
    logic          stall, flush, issue_valid;
    logic [AW-1:0] issue_rd, rs, rt;
    logic          busy_rs, busy_rt, sb_overflow;
    logic [31:0]   retire_cnt;
`ifdef WB_BYPASS_EN
    logic          bypass_hit_rs, bypass_hit_rt;
`endif

    reg_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_writeback #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb            (bus),
        .stall         (stall),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rs            (rs),
        .rt            (rt),
        .busy_rs       (busy_rs),
        .busy_rt       (busy_rt),
`ifdef WB_BYPASS_EN
        .bypass_hit_rs (bypass_hit_rs),
        .bypass_hit_rt (bypass_hit_rt),
`endif
        .sb_overflow   (sb_overflow),
        .retire_cnt    (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the WB entry, outstanding writers per register, counters.
    bit          m_valid, m_regwrite;
    int          m_rd;
    logic [31:0] m_data;
    int          m_pend [NREG];
    bit          m_ovf;
    logic [31:0] m_retires;

    function automatic bit m_we();
        return m_valid && m_regwrite && (m_rd != 0);
    endfunction

    function automatic bit m_retire_now();
        return m_we() && !stall;
    endfunction

    function automatic bit m_hit(int r);
`ifdef WB_BYPASS_EN
        return m_retire_now() && (m_rd == r) && (m_pend[r] == 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_busy(int r);
        return (m_pend[r] != 0) && !m_hit(r);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_regwrite = 0; m_rd = 0; m_data = '0;
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
        m_ovf = 0; m_retires = '0;
    endtask

    task automatic idle();
        stall = 0; flush = 0; issue_valid = 0; issue_rd = '0;
        bus.mem_valid = 0; bus.mem_regWrite = 0; bus.mem_memToReg = 0;
        bus.mem_rd = '0; bus.mem_aluResult = '0; bus.mem_loadData = '0;
    endtask

    task automatic load(int rd, logic [31:0] val);
        bus.mem_valid = 1; bus.mem_regWrite = 1; bus.mem_memToReg = 0;
        bus.mem_rd = AW'(rd); bus.mem_aluResult = val; bus.mem_loadData = ~val;
    endtask

    // Advance one clock, updating the model from the inputs applied before the edge.
    task automatic cycle();
        bit ret;
        bit inc;
        int ird;
        ret = m_retire_now();
        ird = int'(issue_rd);
        inc = issue_valid && (ird != 0);
        if (inc && !(ret && m_rd == ird)) begin
            if (m_pend[ird] == CMAX) m_ovf = 1;
            else m_pend[ird]++;
        end
        if (ret && !(inc && m_rd == ird) && m_pend[m_rd] > 0) m_pend[m_rd]--;
        if (ret) m_retires = m_retires + 32'd1;
        if (!stall) begin
            if (flush) m_valid = 0;
            else begin
                m_valid = bus.mem_valid; m_regwrite = bus.mem_regWrite; m_rd = int'(bus.mem_rd);
                m_data = bus.mem_memToReg ? bus.mem_loadData : bus.mem_aluResult;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1;
        idle();
        #1 rst_n = 0;
        #1;
        checks++; if (bus.writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.writeEnable); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
        checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", sb_overflow); end
        for (int r = 0; r < NREG; r++) begin
            rs = AW'(r); rt = AW'(r); #1;
            checks++;
            if (busy_rs !== 1'b0 || busy_rt !== 1'b0) begin
                errors++; $display("FAIL reset_busy r=%0d got %b%b want 00", r, busy_rs, busy_rt);
            end
        end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_write_path();
        bus.mem_valid = 1; bus.mem_regWrite = 1; bus.mem_memToReg = 1; bus.mem_rd = 5'd5;
        bus.mem_loadData = 32'hDEADBEEF; bus.mem_aluResult = 32'h1;
        cycle();
        idle();
        checks++; if (bus.writeEnable !== 1'b1) begin errors++; $display("FAIL wp_we got %b want 1", bus.writeEnable); end
        checks++; if (bus.writeRpoint !== 5'd5) begin errors++; $display("FAIL wp_rpoint got %0d want 5", bus.writeRpoint); end
        checks++; if (bus.writeData !== 32'hDEADBEEF) begin errors++; $display("FAIL wp_data got %h want deadbeef", bus.writeData); end
        cycle();
        checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL wp_retire got %0d want 1", retire_cnt); end
        checks++; if (bus.writeEnable !== 1'b0) begin errors++; $display("FAIL wp_we_after got %b want 0", bus.writeEnable); end
    endtask

    task automatic test_r0();
        load(0, 32'h1234);
        cycle();
        idle();
        checks++; if (bus.writeEnable !== 1'b0) begin errors++; $display("FAIL r0_we got %b want 0", bus.writeEnable); end
        cycle();
        checks++; if (retire_cnt !== m_retires) begin errors++; $display("FAIL r0_retire got %0d want %0d", retire_cnt, m_retires); end
        issue_valid = 1; issue_rd = '0;
        cycle(); cycle();
        idle(); rs = '0; rt = '0; #1;
        checks++; if (busy_rs !== 1'b0 || busy_rt !== 1'b0) begin errors++; $display("FAIL r0_busy got %b%b want 00", busy_rs, busy_rt); end
    endtask

    task automatic test_scoreboard();
        idle(); rs = 5'd7; rt = 5'd6;
        issue_valid = 1; issue_rd = 5'd7;
        cycle(); cycle();
        issue_valid = 0; #1;
        checks++; if (busy_rs !== 1'b1 || busy_rt !== 1'b0) begin errors++; $display("FAIL sb_two_issued got %b%b want 10", busy_rs, busy_rt); end
        load(7, 32'h77); cycle(); idle(); cycle();
        checks++; if (busy_rs !== 1'b1) begin errors++; $display("FAIL sb_one_retired got %b want 1", busy_rs); end
        load(7, 32'h78); cycle(); idle(); #1;
        checks++; if (busy_rs !== m_busy(7)) begin errors++; $display("FAIL sb_last_inflight got %b want %b", busy_rs, m_busy(7)); end
        cycle();
        checks++; if (busy_rs !== 1'b0) begin errors++; $display("FAIL sb_drained got %b want 0", busy_rs); end
        // issue and retire to the same register in one cycle must cancel
        issue_valid = 1; issue_rd = 5'd7; cycle();
        load(7, 32'h79); issue_valid = 0; cycle();
        idle(); issue_valid = 1; issue_rd = 5'd7; cycle();
        idle(); #1;
        checks++; if (busy_rs !== 1'b1) begin errors++; $display("FAIL sb_same_cycle got %b want 1", busy_rs); end
        load(7, 32'h7A); cycle(); idle(); cycle();
        checks++; if (busy_rs !== 1'b0) begin errors++; $display("FAIL sb_same_cycle_drain got %b want 0", busy_rs); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] r0;
        idle(); load(9, 32'h99); cycle();
        idle(); load(4, 32'h44); stall = 1;
        r0 = m_retires;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (bus.writeEnable !== 1'b1 || bus.writeRpoint !== 5'd9 || bus.writeData !== 32'h99 || retire_cnt !== r0) begin
                errors++;
                $display("FAIL stall_hold k=%0d got we=%b rd=%0d data=%h ret=%0d want 1/9/99/%0d",
                         k, bus.writeEnable, bus.writeRpoint, bus.writeData, retire_cnt, r0);
            end
        end
        idle(); cycle();
        checks++; if (retire_cnt !== r0 + 32'd1) begin errors++; $display("FAIL stall_release got %0d want %0d", retire_cnt, r0 + 32'd1); end
        load(10, 32'hA0); flush = 1; cycle();
        checks++; if (bus.writeEnable !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", bus.writeEnable); end
        load(11, 32'hB0); flush = 0; cycle();
        load(12, 32'hC0); stall = 1; flush = 1; cycle();
        checks++;
        if (bus.writeEnable !== 1'b1 || bus.writeRpoint !== 5'd11 || bus.writeData !== 32'hB0) begin
            errors++;
            $display("FAIL stall_over_flush got we=%b rd=%0d data=%h want 1/11/b0", bus.writeEnable, bus.writeRpoint, bus.writeData);
        end
        idle(); cycle();
    endtask

    task automatic test_overflow();
        idle(); rs = 5'd3; rt = 5'd3;
        issue_valid = 1; issue_rd = 5'd3;
        for (int k = 0; k < 4; k++) cycle();
        idle(); #1;
        checks++; if (sb_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", sb_overflow); end
        checks++; if (busy_rs !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b want 1", busy_rs); end
        // saturated at 3: three retires must drain it completely
        load(3, 32'h31); cycle();
        load(3, 32'h32); cycle();
        load(3, 32'h33); cycle();
        idle(); #1;
        checks++; if (busy_rs !== m_busy(3)) begin errors++; $display("FAIL ovf_last_inflight got %b want %b", busy_rs, m_busy(3)); end
`ifdef WB_BYPASS_EN
        checks++;
        if (busy_rs !== 1'b0 || bypass_hit_rs !== 1'b1 || bypass_hit_rt !== 1'b1) begin
            errors++; $display("FAIL bypass_hit got busy=%b hit=%b%b want 0/11", busy_rs, bypass_hit_rs, bypass_hit_rt);
        end
`endif
        cycle(); cycle();
        checks++; if (busy_rs !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", busy_rs); end
        checks++; if (sb_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", sb_overflow); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_rd = AW'($urandom_range(0, 7));
            bus.mem_valid = ($urandom_range(0, 3) != 0);
            bus.mem_regWrite = ($urandom_range(0, 4) != 0);
            bus.mem_memToReg = $urandom_range(0, 1);
            bus.mem_rd = AW'($urandom_range(0, 7));
            bus.mem_aluResult = $urandom;
            bus.mem_loadData = $urandom;
            rs = AW'($urandom_range(0, 7));
            rt = AW'($urandom_range(0, 7));
            #1;
            checks++;
            if (bus.writeEnable !== m_we() || retire_cnt !== m_retires || sb_overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd_ctrl n=%0d got we=%b ret=%0d ovf=%b want %b/%0d/%b",
                         n, bus.writeEnable, retire_cnt, sb_overflow, m_we(), m_retires, m_ovf);
            end
            if (m_we()) begin
                checks++;
                if (bus.writeRpoint !== AW'(m_rd) || bus.writeData !== m_data) begin
                    errors++;
                    $display("FAIL rnd_port n=%0d got rd=%0d data=%h want %0d/%h", n, bus.writeRpoint, bus.writeData, m_rd, m_data);
                end
            end
            checks++;
            if (busy_rs !== m_busy(int'(rs)) || busy_rt !== m_busy(int'(rt))) begin
                errors++;
                $display("FAIL rnd_busy n=%0d rs=%0d rt=%0d got %b%b want %b%b",
                         n, rs, rt, busy_rs, busy_rt, m_busy(int'(rs)), m_busy(int'(rt)));
            end
`ifdef WB_BYPASS_EN
            checks++;
            if (bypass_hit_rs !== m_hit(int'(rs)) || bypass_hit_rt !== m_hit(int'(rt))) begin
                errors++;
                $display("FAIL rnd_hit n=%0d got %b%b want %b%b", n, bypass_hit_rs, bypass_hit_rt, m_hit(int'(rs)), m_hit(int'(rt)));
            end
`endif
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        idle(); load(6, 32'h66); issue_valid = 1; issue_rd = 5'd6;
        cycle();
        #3 rst_n = 0;
        #1;
        checks++;
        if (bus.writeEnable !== 1'b0 || retire_cnt !== 32'd0 || sb_overflow !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl got we=%b ret=%0d ovf=%b want 0/0/0", bus.writeEnable, retire_cnt, sb_overflow);
        end
        for (int r = 0; r < NREG; r++) begin
            rs = AW'(r); rt = AW'(r); #0.1;
            checks++;
            if (busy_rs !== 1'b0 || busy_rt !== 1'b0) begin
                errors++; $display("FAIL midreset_busy r=%0d got %b%b want 00", r, busy_rs, busy_rt);
            end
        end
        idle();
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        load(2, 32'h22); cycle(); idle(); cycle();
        checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL midreset_resume got %0d want 1", retire_cnt); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_path();
        test_r0();
        test_scoreboard();
        test_stall_flush();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
